// File: rtl/sram_req_ctrl_if.sv
// Request/response handshake bundle between the SoC bus slave and sram_req_ctrl.
interface sram_req_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [18:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_wstrb;
    logic        resp_valid;
    logic        resp_ready;
    logic        resp_write;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, req_wstrb, resp_ready,
        input  req_ready, resp_valid, resp_write, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, req_wstrb, resp_ready,
        output req_ready, resp_valid, resp_write, resp_rdata, resp_err
    );
endinterface

// File: rtl/sram_req_ctrl.sv
// Valid/ready front end for SRAM_512k: issues accesses, captures read data one cycle later,
// and returns in-order responses through a credit-protected FIFO. Optional: SRAM_REQ_CTRL_ALIGN_CHECK_EN.
module sram_req_ctrl #(
    parameter int FIFO_DEPTH = 3
) (
    input  logic           clk,
    input  logic           rst,
    sram_req_ctrl_if.slave bus,
    output logic           o_sram_cs,
    output logic           o_sram_oe,
    output logic [3:0]     o_sram_web,
    output logic [16:0]    o_sram_a,
    output logic [31:0]    o_sram_di,
    input  logic [31:0]    i_sram_do
);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    typedef struct packed {
        logic        write;
        logic [31:0] rdata;
        logic        err;
    } resp_t;

    logic          r_pend;
    logic          r_pend_write;
    logic          r_pend_err;
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    resp_t         r_mem [FIFO_DEPTH];

    logic          w_accept;
    logic          w_misalign;
    logic          w_push;
    logic          w_pop;
    logic [CW:0]   w_used;
    resp_t         w_push_entry;
    resp_t         w_head;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

`ifdef SRAM_REQ_CTRL_ALIGN_CHECK_EN
    assign w_misalign = (bus.req_addr[1:0] != 2'b00);
`else
    assign w_misalign = 1'b0;
`endif

    // One credit per FIFO slot; an in-flight access already owns the slot it will push into.
    assign w_used        = {1'b0, r_count} + {{CW{1'b0}}, r_pend};
    assign bus.req_ready = (w_used < (CW+1)'(FIFO_DEPTH));
    assign w_accept      = bus.req_valid && bus.req_ready && !rst;

    always_comb begin
        // NOTE: every output gets a default first, so no path through this block infers a latch.
        o_sram_cs  = 1'b0;
        o_sram_web = 4'hF;
        o_sram_a   = bus.req_addr[18:2];
        o_sram_di  = bus.req_wdata;
        if (w_accept && !w_misalign) begin
            o_sram_cs = 1'b1;
            if (bus.req_write) begin
                o_sram_web = ~bus.req_wstrb;
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            r_pend       <= 1'b0;
            r_pend_write <= 1'b0;
            r_pend_err   <= 1'b0;
        end else begin
            r_pend       <= w_accept;
            r_pend_write <= bus.req_write;
            r_pend_err   <= w_misalign;
        end
    end

    // The SRAM output follows its address latch, so read data is only valid in the cycle after issue.
    assign o_sram_oe          = r_pend && !r_pend_write;
    assign w_push             = r_pend;
    assign w_push_entry.write = r_pend_write;
    assign w_push_entry.rdata = (r_pend_write || r_pend_err) ? 32'h0 : i_sram_do;
    assign w_push_entry.err   = r_pend_err;
    assign w_pop              = bus.resp_valid && bus.resp_ready;

    always_ff @(posedge clk) begin
        // NOTE: storage is not reset; the resp_* outputs are masked by resp_valid so stale entries never show.
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_push_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= next_ptr(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= next_ptr(r_rd_ptr);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CW'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

    assign w_head         = r_mem[r_rd_ptr];
    assign bus.resp_valid = (r_count != '0);
    assign bus.resp_write = bus.resp_valid && w_head.write;
    assign bus.resp_rdata = bus.resp_valid ? w_head.rdata : 32'h0;
    assign bus.resp_err   = bus.resp_valid && w_head.err;
endmodule

// File: tb/tb_sram_req_ctrl.sv
// Directed bench for sram_req_ctrl: vector table plus streaming, backpressure and reset sequences.
module tb_sram_req_ctrl;
    logic        clk;
    logic        rst;
    logic        sram_cs;
    logic        sram_oe;
    logic [3:0]  sram_web;
    logic [16:0] sram_a;
    logic [31:0] sram_di;
    logic [31:0] sram_do;

    int n_checks;
    int n_fail;

    sram_req_ctrl_if bus ();

    sram_req_ctrl #(.FIFO_DEPTH(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .o_sram_cs  (sram_cs),
        .o_sram_oe  (sram_oe),
        .o_sram_web (sram_web),
        .o_sram_a   (sram_a),
        .o_sram_di  (sram_di),
        .i_sram_do  (sram_do)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM model: address latched every edge, byte writes under CS, output follows latched address.
    logic [31:0] mem [0:131071];
    logic [16:0] lat_a;
    initial lat_a = '0;
    always @(posedge clk) begin
        lat_a <= sram_a;
        if (sram_cs) begin
            for (int b = 0; b < 4; b++) begin
                if (!sram_web[b]) mem[sram_a][8*b +: 8] <= sram_di[8*b +: 8];
            end
        end
    end
    assign sram_do = sram_oe ? mem[lat_a] : 32'hBAD0_BAD0;

    typedef struct {
        logic        write;
        logic [18:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        exp_cs;
        logic [16:0] exp_a;
        logic [3:0]  exp_web;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic drive(input logic w, input logic [18:0] a, input logic [31:0] d, input logic [3:0] s);
        bus.req_valid = 1'b1;
        bus.req_write = w;
        bus.req_addr  = a;
        bus.req_wdata = d;
        bus.req_wstrb = s;
    endtask

    task automatic idle();
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.req_wstrb = '0;
    endtask

    function automatic logic [31:0] bank_data(input int k);
        return 32'hB000_0000 + 32'(k) * 32'h0101_0101;
    endfunction

    function automatic logic [18:0] bank_addr(input int k);
        return 19'(k) << 16;
    endfunction

    logic [31:0] popped [$];
    logic [31:0] head;
    logic        have_head;
    int          accepts;

    initial begin
        n_checks = 0;
        n_fail   = 0;

        vecs[0] = '{1'b1, 19'h7FFFC, 32'hDEADBEEF, 4'hF, 1'b1, 17'h1FFFF, 4'h0, 32'h0,        1'b0};
        vecs[1] = '{1'b0, 19'h7FFFC, 32'h0,        4'h0, 1'b1, 17'h1FFFF, 4'hF, 32'hDEADBEEF, 1'b0};
        vecs[2] = '{1'b1, 19'h00010, 32'h11223344, 4'hF, 1'b1, 17'h00004, 4'h0, 32'h0,        1'b0};
        vecs[3] = '{1'b1, 19'h00010, 32'hAABBCCDD, 4'h5, 1'b1, 17'h00004, 4'hA, 32'h0,        1'b0};
        vecs[4] = '{1'b0, 19'h00010, 32'h0,        4'h0, 1'b1, 17'h00004, 4'hF, 32'h11BB33DD, 1'b0};
        vecs[5] = '{1'b1, 19'h00020, 32'hCAFEF00D, 4'hF, 1'b1, 17'h00008, 4'h0, 32'h0,        1'b0};
        vecs[6] = '{1'b1, 19'h00020, 32'h12345678, 4'h0, 1'b1, 17'h00008, 4'hF, 32'h0,        1'b0};
        vecs[7] = '{1'b0, 19'h00020, 32'h0,        4'h0, 1'b1, 17'h00008, 4'hF, 32'hCAFEF00D, 1'b0};
        vecs[8] = '{1'b1, 19'h00004, 32'h5A5A5A5A, 4'hF, 1'b1, 17'h00001, 4'h0, 32'h0,        1'b0};
`ifdef SRAM_REQ_CTRL_ALIGN_CHECK_EN
        vecs[9] = '{1'b0, 19'h00006, 32'h0,        4'h0, 1'b0, 17'h00001, 4'hF, 32'h0,        1'b1};
`else
        vecs[9] = '{1'b0, 19'h00006, 32'h0,        4'h0, 1'b1, 17'h00001, 4'hF, 32'h5A5A5A5A, 1'b0};
`endif

        // Reset with a request presented: nothing may be accepted.
        rst = 1'b1;
        drive(1'b1, 19'h00040, 32'hFFFF_FFFF, 4'hF);
        bus.resp_ready = 1'b1;
        repeat (2) begin
            @(posedge clk); #2;
            check("rst_cs", 32'(sram_cs), 32'h0);
            check("rst_web", 32'(sram_web), 32'hF);
            check("rst_oe", 32'(sram_oe), 32'h0);
            check("rst_resp_valid", 32'(bus.resp_valid), 32'h0);
            check("rst_req_ready", 32'(bus.req_ready), 32'h1);
            check("rst_resp_write", 32'(bus.resp_write), 32'h0);
            check("rst_resp_rdata", bus.resp_rdata, 32'h0);
            check("rst_resp_err", 32'(bus.resp_err), 32'h0);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        idle();
        #1 check("post_rst_valid0", 32'(bus.resp_valid), 32'h0);
        @(posedge clk); #2;
        check("post_rst_valid1", 32'(bus.resp_valid), 32'h0);

        // Single isolated requests from the table.
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            drive(vecs[i].write, vecs[i].addr, vecs[i].wdata, vecs[i].wstrb);
            #1;
            check($sformatf("v%0d_ready", i), 32'(bus.req_ready), 32'h1);
            check($sformatf("v%0d_cs", i), 32'(sram_cs), 32'(vecs[i].exp_cs));
            if (vecs[i].exp_cs) check($sformatf("v%0d_a", i), 32'(sram_a), 32'(vecs[i].exp_a));
            check($sformatf("v%0d_web", i), 32'(sram_web), 32'(vecs[i].exp_web));
            @(posedge clk); #1;
            idle();
            #1;
            check($sformatf("v%0d_t1_valid", i), 32'(bus.resp_valid), 32'h0);
            check($sformatf("v%0d_t1_oe", i), 32'(sram_oe), 32'(!vecs[i].write));
            @(posedge clk); #2;
            check($sformatf("v%0d_t2_valid", i), 32'(bus.resp_valid), 32'h1);
            check($sformatf("v%0d_t2_write", i), 32'(bus.resp_write), 32'(vecs[i].write));
            check($sformatf("v%0d_t2_rdata", i), bus.resp_rdata, vecs[i].exp_rdata);
            check($sformatf("v%0d_t2_err", i), 32'(bus.resp_err), 32'(vecs[i].exp_err));
            @(posedge clk); #2;
            check($sformatf("v%0d_t3_valid", i), 32'(bus.resp_valid), 32'h0);
        end

        // Streaming writes then reads across all eight 64 KB banks.
        for (int pass = 0; pass < 2; pass++) begin
            for (int c = 0; c < 12; c++) begin
                @(posedge clk); #1;
                if (c < 8) drive(pass == 0, bank_addr(c), bank_data(c), 4'hF);
                else idle();
                #1;
                if (c < 8) check($sformatf("s%0d_ready_%0d", pass, c), 32'(bus.req_ready), 32'h1);
                if (c >= 2 && c < 10) begin
                    check($sformatf("s%0d_valid_%0d", pass, c), 32'(bus.resp_valid), 32'h1);
                    check($sformatf("s%0d_write_%0d", pass, c), 32'(bus.resp_write), 32'(pass == 0));
                    check($sformatf("s%0d_rdata_%0d", pass, c), bus.resp_rdata,
                          (pass == 0) ? 32'h0 : bank_data(c - 2));
                end
                if (c >= 10) check($sformatf("s%0d_drained_%0d", pass, c), 32'(bus.resp_valid), 32'h0);
            end
        end

        // Backpressure: continuous reads with resp_ready low.
        bus.resp_ready = 1'b0;
        accepts   = 0;
        have_head = 1'b0;
        head      = '0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            drive(1'b0, bank_addr(accepts), 32'h0, 4'h0);
            #1;
            if (bus.req_valid && bus.req_ready) accepts++;
            if (bus.resp_valid) begin
                if (!have_head) begin
                    head      = bus.resp_rdata;
                    have_head = 1'b1;
                end else begin
                    check($sformatf("bp_head_stable_%0d", c), bus.resp_rdata, head);
                end
            end
        end
        check("bp_accepts", 32'(accepts), 32'd3);
        check("bp_ready_low", 32'(bus.req_ready), 32'h0);
        check("bp_head_value", head, bank_data(0));
        @(posedge clk); #1;
        bus.resp_ready = 1'b1;
        #1;
        check("bp_ready_still_low", 32'(bus.req_ready), 32'h0);
        if (bus.resp_valid) popped.push_back(bus.resp_rdata);
        @(posedge clk); #1;
        bus.resp_ready = 1'b0;
        #1;
        check("bp_ready_back", 32'(bus.req_ready), 32'h1);
        if (bus.req_valid && bus.req_ready) accepts++;
        @(posedge clk); #1;
        idle();
        bus.resp_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            #1;
            if (bus.resp_valid) popped.push_back(bus.resp_rdata);
            @(posedge clk); #1;
        end
        check("bp_total_accepts", 32'(accepts), 32'd4);
        check("bp_pop_count", 32'(popped.size()), 32'd4);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("bp_pop_%0d", k), (k < popped.size()) ? popped[k] : 32'hDEAD_0000, bank_data(k));
        end

        // Reset with two queued responses discards them.
        bus.resp_ready = 1'b0;
        drive(1'b0, bank_addr(5), 32'h0, 4'h0);
        @(posedge clk); #1;
        drive(1'b0, bank_addr(6), 32'h0, 4'h0);
        @(posedge clk); #1;
        idle();
        @(posedge clk); #2;
        check("mrst_queued_valid", 32'(bus.resp_valid), 32'h1);
        check("mrst_queued_head", bus.resp_rdata, bank_data(5));
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #2;
        check("mrst_valid", 32'(bus.resp_valid), 32'h0);
        check("mrst_ready", 32'(bus.req_ready), 32'h1);
        #1;
        rst = 1'b0;
        bus.resp_ready = 1'b1;
        @(posedge clk); #2;
        check("mrst_after_valid", 32'(bus.resp_valid), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/sram_req_ctrl.md
# sram_req_ctrl

Request/response front end for the 512 KB data SRAM (`SRAM_512k`). It accepts byte-addressed read/write requests over a valid/ready handshake and drives the SRAM's `CS/OE/WEB/A/DI` pins. It captures read data in the cycle after the access and returns in-order responses through a 3-entry response FIFO, so backpressure never drops data. It sits between the SoC bus slave interface and `SRAM_512k`.

## Interface
- `FIFO_DEPTH`, 3: response FIFO entries; minimum 3 for full throughput.
- `clk` input 1: single clock, also drives the SRAM's `CK`.
- `rst` input 1: synchronous, active-high reset.
- `req_valid` input 1: request present.
- `req_ready` output 1: request accepted when `req_valid && req_ready`.
- `req_write` input 1: 1 = write, 0 = read.
- `req_addr` input 19: byte address.
- `req_wdata` input 32: write data.
- `req_wstrb` input 4: byte enables, active-high.
- `resp_valid` output 1: response present.
- `resp_ready` input 1: response consumed when `resp_valid && resp_ready`.
- `resp_write` output 1: response belongs to a write.
- `resp_rdata` output 32: read data; 0 for writes.
- `resp_err` output 1: misaligned-access error (see Configuration).
- `sram_cs` output 1: SRAM chip select.
- `sram_oe` output 1: SRAM output enable.
- `sram_web` output 4: SRAM byte write enables, active-low.
- `sram_a` output 17: SRAM word address.
- `sram_di` output 32: SRAM write data.
- `sram_do` input 32: SRAM read data.

## Operation
- **Issue (cycle T, on request accept).** The SRAM pins are driven combinationally:
  - `sram_cs = 1`
  - `sram_a = req_addr[18:2]`
  - `sram_di = req_wdata`
  - `sram_web = req_write ? ~req_wstrb : 4'hF`
- **Idle cycles.** When no request is accepted: `sram_cs = 0`, `sram_web = 4'hF`. `sram_a` and `sram_di` are don't-care.
- **Pending register.** `pend` (1 bit) plus `pend_write` is set on accept and cleared otherwise.
- **Capture (cycle T+1, `pend = 1`).**
  - `sram_oe = pend && !pend_write`.
  - The FIFO pushes `{write = pend_write, rdata = pend_write ? 0 : sram_do, err = 0}`.
  - Capture happens exactly at T+1 because the SRAM's data mux follows its latched address, which updates every cycle.
- **Flow control.**
  - `req_ready = (fifo_count + pend) < FIFO_DEPTH`, derived only from registers.
  - There is no combinational path from `resp_ready` to `req_ready`.
- **Response FIFO.**
  - `resp_valid = (fifo_count != 0)`; the `resp_*` outputs show the FIFO head.
  - Push and pop in the same cycle leave the count unchanged.
  - Pointers wrap modulo `FIFO_DEPTH`.
  - The FIFO never overflows, because the credit rule reserves a slot for every pending access.
- **Write with `req_wstrb = 0`.** `sram_cs = 1` with `WEB = 4'hF`; no byte is modified, and a write response is still returned.
- **Ordering.** Responses return strictly in request order.
- **Reset.**
  - `pend = 0`; FIFO pointers and count = 0.
  - Outputs: `req_ready = 1`, `resp_valid = 0`, `resp_write = 0`, `resp_rdata = 0`, `resp_err = 0`, `sram_cs = 0`, `sram_oe = 0`, `sram_web = 4'hF`.
  - Reset mid-operation discards pending and queued responses. A write whose CS cycle already occurred stays committed in the SRAM.
  - A request presented during reset is not accepted.

## Timing
- Request accepted in cycle T → SRAM access in cycle T → data captured at the end of T+1 → `resp_valid` no earlier than T+2. Reads and writes have the same latency.
- Throughput is one request per cycle while `resp_ready` stays high.
- Under sustained `resp_ready = 0`, at most 3 requests are accepted before `req_ready` drops. It reasserts the cycle after the first pop frees a credit.
- `resp_*` must hold stable while `resp_valid && !resp_ready`.

## Configuration
- **`SRAM_REQ_CTRL_ALIGN_CHECK_EN` defined.**
  - A request with `req_addr[1:0] != 0` is accepted normally but does not touch the SRAM: `sram_cs = 0` in cycle T.
  - It takes the same pending slot, and its FIFO entry carries `err = 1`, `rdata = 0`.
  - Its latency and ordering are identical to a normal access.
- **Not defined.**
  - `req_addr[1:0]` is ignored and every request accesses the SRAM.
  - `resp_err` is tied to 0.

## Test plan
- **Reset values.** Hold `rst` high 2 cycles with `req_valid = 1` → no accept, `sram_cs = 0`, `sram_web = F`, `resp_valid = 0`, `req_ready = 1`.
- **Write then read.**
  - Stimulus: write `0x7FFFC` with `0xDEADBEEF`, `wstrb = F`; then read `0x7FFFC`.
  - Required: `sram_a = 0x1FFFF` on both; write response `resp_write = 1`; read response `rdata = 0xDEADBEEF`, each at accept+2.
- **Partial write.**
  - Stimulus: write `0x11223344` to `0x00010`; then write `0xAABBCCDD` with `wstrb = 0101`; then read.
  - Required: `sram_web = 1010` on the second write; read returns `0x11BB33DD`.
- **Streaming.** 8 back-to-back reads of distinct addresses spanning all eight 64 KB banks (`0x00000`, `0x10000`, … `0x70000`) with `resp_ready = 1` → `req_ready` never drops; 8 in-order correct responses on consecutive cycles starting T+2.
- **Backpressure.**
  - Stimulus: `resp_ready = 0`, continuous `req_valid`.
  - Required: exactly 3 accepts, then `req_ready = 0`, with the response head held stable. Raising `resp_ready` for 1 cycle → `req_ready = 1` the next cycle. No data is lost.
- **Misaligned access.**
  - With `SRAM_REQ_CTRL_ALIGN_CHECK_EN`: read `0x00006` → `sram_cs = 0`, response `err = 1`, `rdata = 0`.
  - Without it: `sram_a = 0x00001`, `err = 0`.
  - Reset mid-stream also checked: reset asserted with 2 queued responses → `resp_valid = 0` the next cycle.
